// File: rtl/spi_pkt_rx.sv
// spi_pkt_rx: SPI mode-0 slave receiver, MSB-first PKT_W-bit packets into a one-entry vld/rdy register; ports clk/rst, sclk/sdi/ss serial in, pkt/vld/rdy out, busy, ovf/ferr pulses
module spi_pkt_rx #(
  parameter int PKT_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdi,
  input  logic             ss,
  output logic [PKT_W-1:0] pkt,
  output logic             vld,
  input  logic             rdy,
  output logic             busy,
  output logic             ovf,
  output logic             ferr
);
  localparam int CW = $clog2(PKT_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_s, sdi_s, ss_s;
  logic sclk_p, ss_p, sclk_rise, sdi_sync, ss_sync, ss_rise;
  logic [CW-1:0] cnt, cnt_n;
  logic [PKT_W-1:0] shreg, shreg_n;
  logic extra, extra_n, commit, ferr_n;
  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_p;
  assign sdi_sync = sdi_s[SYNC_STAGES-1];
  assign ss_sync = ss_s[SYNC_STAGES-1];
  assign ss_rise = ss_sync & ~ss_p;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      sdi_s <= '0;
      ss_s <= '1;
      sclk_p <= 1'b0;
      ss_p <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      extra <= 1'b0;
      pkt <= '0;
      vld <= 1'b0;
      ovf <= 1'b0;
      ferr <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      sdi_s <= {sdi_s[SYNC_STAGES-2:0], sdi};
      ss_s <= {ss_s[SYNC_STAGES-2:0], ss};
      sclk_p <= sclk_s[SYNC_STAGES-1];
      ss_p <= ss_sync;
      state <= state_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      extra <= extra_n;
      ferr <= ferr_n;
      ovf <= commit & vld & ~rdy;
      if (commit && !(vld && !rdy)) begin
        pkt <= shreg_n;
        vld <= 1'b1;
      end else if (vld && rdy) vld <= 1'b0;
    end
  end
  // ss is acted on by level: a frame opened right after reset with no sclk
  // activity closes at the ss rise with cnt==0 and raises no error.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shreg_n = shreg;
    extra_n = extra;
    commit = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: if (!ss_sync) begin
        state_n = SHIFT;
        cnt_n = '0;
      end
      SHIFT: if (ss_sync) begin
        state_n = IDLE;
        ferr_n = (cnt != '0) | (ss_rise & 1'b0);
      end else if (sclk_rise) begin
        shreg_n = {shreg[PKT_W-2:0], sdi_sync};
        cnt_n = cnt + 1'b1;
        commit = cnt_n == CW'(PKT_W);
        state_n = commit ? DONE : SHIFT;
        extra_n = 1'b0;
      end
      DONE: if (ss_sync) state_n = IDLE;
      else if (sclk_rise && !extra) begin
        ferr_n = 1'b1;
        extra_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_pkt_rx.sv
// tb_spi_pkt_rx: directed self-checking bench for spi_pkt_rx with hand-computed packets
module tb_spi_pkt_rx;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, sdi = 1'b0, ss = 1'b1, rdy = 1'b0;
  logic [15:0] pkt;
  logic vld, busy, ovf, ferr;
  int n_vec = 0, n_err = 0, ferr_cnt = 0, ovf_cnt = 0, f0, o0;
  logic [15:0] hs_q[$];
  spi_pkt_rx #(.PKT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .ss(ss),
    .pkt(pkt), .vld(vld), .rdy(rdy), .busy(busy), .ovf(ovf), .ferr(ferr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovf) ovf_cnt++;
    if (vld && rdy) hs_q.push_back(pkt);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pop_hs();
    if (hs_q.size() == 0) return 32'hxxxx_xxxx;
    return {16'h0, hs_q.pop_front()};
  endfunction
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bits(input logic [15:0] d, input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) begin
      sdi = (i < 16) ? d[15-i] : 1'b0;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
      if (gap > 0 && i == 7) wait_clk(gap);
    end
  endtask
  task automatic frame(input logic [15:0] d, input int nb, input int gap);
    ss = 1'b0;
    wait_clk(4);
    bits(d, 0, nb, gap);
    wait_clk(4);
    ss = 1'b1;
    wait_clk(6);
  endtask
  task automatic pulse_rdy();
    rdy = 1'b1;
    wait_clk(1);
    rdy = 1'b0;
  endtask
  initial begin
    wait_clk(3);
    check("rst_vld", vld, 0);
    check("rst_pkt", pkt, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ferr", ferr, 0);
    rst = 1'b0;
    wait_clk(2);
    // 1: single frame, latency of the final bit
    ss = 1'b0;
    wait_clk(4);
    check("t1_busy", busy, 1);
    bits(16'hA55A, 0, 15, 0);
    sdi = 1'b0;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(2);
    check("t1_vld_early", vld, 0);
    wait_clk(1);
    check("t1_vld", vld, 1);
    check("t1_pkt", pkt, 16'hA55A);
    wait_clk(1);
    sclk = 1'b0;
    wait_clk(4);
    ss = 1'b1;
    wait_clk(6);
    check("t1_idle", busy, 0);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovf", ovf_cnt, 0);
    pulse_rdy();
    check("t1_vld_clr", vld, 0);
    check("t1_hs", pop_hs(), 16'hA55A);
    // 2: overflow with rdy held low
    o0 = ovf_cnt;
    frame(16'h1234, 16, 0);
    frame(16'hBEEF, 16, 0);
    check("t2_pkt", pkt, 16'h1234);
    check("t2_vld", vld, 1);
    check("t2_ovf", ovf_cnt - o0, 1);
    check("t2_ferr", ferr_cnt, 0);
    pulse_rdy();
    check("t2_vld_clr", vld, 0);
    check("t2_hs", pop_hs(), 16'h1234);
    check("t2_hs_n", hs_q.size(), 0);
    // 3: inter-byte gaps, rdy high
    rdy = 1'b1;
    frame(16'h00FF, 16, 50);
    frame(16'hFF00, 16, 50);
    rdy = 1'b0;
    check("t3_hs_n", hs_q.size(), 2);
    check("t3_hs0", pop_hs(), 16'h00FF);
    check("t3_hs1", pop_hs(), 16'hFF00);
    check("t3_vld", vld, 0);
    // 4: aborted frame then good frame
    f0 = ferr_cnt;
    frame(16'hFFFF, 9, 0);
    check("t4_ferr", ferr_cnt - f0, 1);
    check("t4_vld", vld, 0);
    rdy = 1'b1;
    frame(16'h8001, 16, 0);
    rdy = 1'b0;
    check("t4_hs", pop_hs(), 16'h8001);
    check("t4_ferr2", ferr_cnt - f0, 1);
    // 5: extra sclk rise
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    frame(16'hC3C3, 17, 0);
    check("t5_pkt", pkt, 16'hC3C3);
    check("t5_vld", vld, 1);
    check("t5_ferr", ferr_cnt - f0, 1);
    check("t5_ovf", ovf_cnt - o0, 0);
    pulse_rdy();
    void'(pop_hs());
    // 6: reset mid-frame
    f0 = ferr_cnt;
    ss = 1'b0;
    wait_clk(4);
    bits(16'hFFFF, 0, 10, 0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    wait_clk(10);
    ss = 1'b1;
    wait_clk(6);
    check("t6_vld", vld, 0);
    check("t6_ferr", ferr_cnt - f0, 0);
    check("t6_busy", busy, 0);
    frame(16'h5AA5, 16, 0);
    check("t6_pkt", pkt, 16'h5AA5);
    check("t6_vld2", vld, 1);
    check("t6_hs_n", hs_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
